uart_receiver: RTL and testbench

//  UART serial receiver: recovers 8N1/8P1-style frames from rxd using a x16 oversampling enable.

---
 rtl/uart_receiver.sv | 213 +++++++++++++++++++++
 tb/tb_uart_receiver.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1/8P1-style UART receive path driven by a x16 oversampling enable.
// rxd is brought into the sysclk domain through a two-flop synchronizer. A one-hot
// FSM then confirms the start bit at mid-bit, samples each data, parity and stop bit
// at mid-bit, and presents the word with a single-cycle rx_valid strobe and error flags.
module uart_receiver #(
    parameter int DBITS      = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic             sysclk,
    input  logic             rst,
    input  logic             baudx16_en,
    input  logic             odd_even,
    input  logic             parity_en,
    input  logic             rxd,
    output logic [DBITS-1:0] rx_data,
    output logic             rx_valid,
    output logic             parity_err,
    output logic             frame_err,
    output logic             rx_busy
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = 3;

    // Start-bit confirmation point and the last tick of a bit period.
    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DBITS - 1);

    typedef enum logic [5:0] {
        S_IDLE   = 6'b000001,
        S_START  = 6'b000010,
        S_DATA   = 6'b000100,
        S_PARITY = 6'b001000,
        S_STOP   = 6'b010000,
        S_BREAK  = 6'b100000
    } state_t;

    // Synchronizer
    logic sync1_q;
    logic sync2_q;
    logic rxd_s;

    // FSM state and datapath
    state_t             state_q,      state_d;
    logic [TICK_W-1:0]  tick_cnt_q,   tick_cnt_d;
    logic [BIT_W-1:0]   bit_cnt_q,    bit_cnt_d;
    logic [DBITS-1:0]   shift_q,      shift_d;
    logic               odd_even_q,   odd_even_d;
    logic               par_en_q,     par_en_d;
    logic               perr_pend_q,  perr_pend_d;

    // Registered outputs
    logic [DBITS-1:0]   rx_data_q,    rx_data_d;
    logic               rx_valid_q,   rx_valid_d;
    logic               parity_err_q, parity_err_d;
    logic               frame_err_q,  frame_err_d;
    logic               rx_busy_q,    rx_busy_d;

    // Two-flop synchronizer, reset to the idle-high line level.
    always_ff @(posedge sysclk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rxd;
            sync2_q <= sync1_q;
        end
    end

    assign rxd_s = sync2_q;

    // Next-state and output computation for the receive FSM.
    always_comb begin
        state_d      = state_q;
        tick_cnt_d   = tick_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        odd_even_d   = odd_even_q;
        par_en_d     = par_en_q;
        perr_pend_d  = perr_pend_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        rx_busy_d    = rx_busy_q;

        case (state_q)
            S_IDLE: begin
                if (baudx16_en && !rxd_s) begin
                    state_d    = S_START;
                    tick_cnt_d = '0;
                end
            end

            S_START: begin
                if (baudx16_en) begin
                    if (tick_cnt_q == TICK_MID) begin
                        if (!rxd_s) begin
                            // Genuine start bit: freeze the frame format for this frame.
                            odd_even_d  = odd_even;
                            par_en_d    = parity_en;
                            perr_pend_d = 1'b0;
                            rx_busy_d   = 1'b1;
                            tick_cnt_d  = '0;
                            bit_cnt_d   = '0;
                            state_d     = S_DATA;
                        end else begin
                            // Line went back high before mid-bit: treat as a glitch.
                            state_d = S_IDLE;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_W'(1);
                    end
                end
            end

            S_DATA: begin
                if (baudx16_en) begin
                    tick_cnt_d = tick_cnt_q + TICK_W'(1);
                    if (tick_cnt_q == TICK_LAST) begin
                        // LSB arrives first, so shifting in at the MSB leaves it at bit 0.
                        shift_d   = {rxd_s, shift_q[DBITS-1:1]};
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        if (bit_cnt_q == BIT_LAST) begin
                            state_d = par_en_q ? S_PARITY : S_STOP;
                        end
                    end
                end
            end

            S_PARITY: begin
                if (baudx16_en) begin
                    tick_cnt_d = tick_cnt_q + TICK_W'(1);
                    if (tick_cnt_q == TICK_LAST) begin
                        // Data plus parity bit XOR to 0 for even, 1 for odd.
                        perr_pend_d = ((^shift_q) ^ rxd_s) != odd_even_q;
                        state_d     = S_STOP;
                    end
                end
            end

            S_STOP: begin
                if (baudx16_en) begin
                    tick_cnt_d = tick_cnt_q + TICK_W'(1);
                    if (tick_cnt_q == TICK_LAST) begin
                        rx_data_d    = shift_q;
                        rx_valid_d   = 1'b1;
                        parity_err_d = perr_pend_q & par_en_q;
                        frame_err_d  = ~rxd_s;
                        if (rxd_s) begin
                            state_d   = S_IDLE;
                            rx_busy_d = 1'b0;
                        end else begin
                            state_d = S_BREAK;
                        end
                    end
                end
            end

            S_BREAK: begin
                // Hold off until the line is released so a break is not seen as a new start.
                if (rxd_s) begin
                    state_d   = S_IDLE;
                    rx_busy_d = 1'b0;
                end
            end

            default: begin
                state_d   = S_IDLE;
                rx_busy_d = 1'b0;
            end
        endcase
    end

    // FSM, counters, shift register and registered outputs.
    always_ff @(posedge sysclk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            tick_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            odd_even_q   <= 1'b0;
            par_en_q     <= 1'b0;
            perr_pend_q  <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            rx_busy_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            odd_even_q   <= odd_even_d;
            par_en_q     <= par_en_d;
            perr_pend_q  <= perr_pend_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            rx_busy_q    <= rx_busy_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign rx_busy    = rx_busy_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: frames are serialised onto rxd at 16 ticks per bit,
// a monitor records each rx_valid pulse, and each test task checks the recorded results.
module tb_uart_receiver;

    logic       sysclk = 1'b0;
    logic       rst = 1'b0;
    logic       baudx16_en = 1'b0;
    logic       odd_even = 1'b0;
    logic       parity_en = 1'b0;
    logic       rxd = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       parity_err;
    logic       frame_err;
    logic       rx_busy;

    int checks = 0;
    int failures = 0;

    // Monitor record
    int         vld_cnt = 0;
    logic [7:0] cap_data [$];
    logic       cap_perr = 1'b0;
    logic       cap_ferr = 1'b0;
    logic       busy_seen = 1'b0;
    int         tick_div = 0;

    uart_receiver #(.DBITS(8), .OVERSAMPLE(16)) dut (
        .sysclk     (sysclk),
        .rst        (rst),
        .baudx16_en (baudx16_en),
        .odd_even   (odd_even),
        .parity_en  (parity_en),
        .rxd        (rxd),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .rx_busy    (rx_busy)
    );

    always #5 sysclk = ~sysclk;

    // x16 enable: one pulse every 4 sysclk, changed on the falling edge.
    always @(negedge sysclk) begin
        tick_div   = (tick_div + 1) % 4;
        baudx16_en = (tick_div == 0);
    end

    // Record every rx_valid pulse and whether rx_busy was ever seen high.
    always @(negedge sysclk) begin
        if (rx_valid) begin
            vld_cnt = vld_cnt + 1;
            cap_data.push_back(rx_data);
            cap_perr = parity_err;
            cap_ferr = frame_err;
        end
        if (rx_busy) busy_seen = 1'b1;
    end

    initial begin
        #3_000_000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic wait_ticks(input int n);
        int k;
        k = 0;
        while (k < n) begin
            @(posedge sysclk);
            if (baudx16_en) k++;
        end
        #1;
    endtask

    task automatic send_bit(input logic b);
        rxd = b;
        wait_ticks(16);
    endtask

    // Start bit, 8 data bits LSB first, optional parity bit, stop bit.
    task automatic send_frame(input logic [7:0] d, input logic par_on, input logic p,
                              input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (par_on) send_bit(p);
        send_bit(stop);
        rxd = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        rxd = 1'b1;
        repeat (4) @(posedge sysclk);
        #1;
        checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
        checks++; if (parity_err !== 1'b0) begin failures++; $display("FAIL reset_parity_err: got %b expected 0", parity_err); end
        checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
        checks++; if (rx_busy !== 1'b0) begin failures++; $display("FAIL reset_rx_busy: got %b expected 0", rx_busy); end
        rst = 1'b1;
        wait_ticks(32);
    endtask

    task automatic test_no_parity;
        int n0;
        logic busy_mid;
        n0 = vld_cnt;
        cap_data.delete();
        parity_en = 1'b0;
        odd_even = 1'b0;
        // 0x55 by hand so rx_busy can be sampled mid-frame.
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(i[0] ? 1'b0 : 1'b1);
        busy_mid = rx_busy;
        for (int i = 4; i < 8; i++) send_bit(i[0] ? 1'b0 : 1'b1);
        send_bit(1'b1);
        wait_ticks(16);
        checks++; if (busy_mid !== 1'b1) begin failures++; $display("FAIL nopar_busy_mid: got %b expected 1", busy_mid); end
        checks++; if (vld_cnt - n0 !== 1) begin failures++; $display("FAIL nopar_valid_count: got %0d expected 1", vld_cnt - n0); end
        checks++; if (cap_data.size() == 0 || cap_data[0] !== 8'h55) begin failures++; $display("FAIL nopar_data: got %h expected 55", rx_data); end
        checks++; if (cap_perr !== 1'b0) begin failures++; $display("FAIL nopar_parity_err: got %b expected 0", cap_perr); end
        checks++; if (cap_ferr !== 1'b0) begin failures++; $display("FAIL nopar_frame_err: got %b expected 0", cap_ferr); end
        checks++; if (rx_busy !== 1'b0) begin failures++; $display("FAIL nopar_busy_after: got %b expected 0", rx_busy); end
    endtask

    task automatic test_even_parity;
        int n0;
        parity_en = 1'b1;
        odd_even = 1'b0;
        // 0xA7 has five ones: even parity requires p=1 for a clean frame.
        n0 = vld_cnt;
        cap_data.delete();
        send_frame(8'hA7, 1'b1, 1'b1, 1'b1);
        wait_ticks(16);
        checks++; if (vld_cnt - n0 !== 1) begin failures++; $display("FAIL even_ok_count: got %0d expected 1", vld_cnt - n0); end
        checks++; if (cap_data.size() == 0 || cap_data[0] !== 8'hA7) begin failures++; $display("FAIL even_ok_data: got %h expected a7", rx_data); end
        checks++; if (cap_perr !== 1'b0) begin failures++; $display("FAIL even_ok_parity_err: got %b expected 0", cap_perr); end
        n0 = vld_cnt;
        cap_data.delete();
        send_frame(8'hA7, 1'b1, 1'b0, 1'b1);
        wait_ticks(16);
        checks++; if (vld_cnt - n0 !== 1) begin failures++; $display("FAIL even_bad_count: got %0d expected 1", vld_cnt - n0); end
        checks++; if (cap_data.size() == 0 || cap_data[0] !== 8'hA7) begin failures++; $display("FAIL even_bad_data: got %h expected a7", rx_data); end
        checks++; if (cap_perr !== 1'b1) begin failures++; $display("FAIL even_bad_parity_err: got %b expected 1", cap_perr); end
    endtask

    task automatic test_odd_parity;
        int n0;
        parity_en = 1'b1;
        odd_even = 1'b1;
        // 0x00 with p=1: one set bit overall, odd parity satisfied.
        n0 = vld_cnt;
        cap_data.delete();
        send_frame(8'h00, 1'b1, 1'b1, 1'b1);
        wait_ticks(16);
        checks++; if (cap_data.size() == 0 || cap_data[0] !== 8'h00) begin failures++; $display("FAIL odd_ok_data: got %h expected 00", rx_data); end
        checks++; if (cap_perr !== 1'b0) begin failures++; $display("FAIL odd_ok_parity_err: got %b expected 0", cap_perr); end
        // 0xFF with p=0: eight set bits, odd parity violated.
        cap_data.delete();
        send_frame(8'hFF, 1'b1, 1'b0, 1'b1);
        wait_ticks(16);
        checks++; if (vld_cnt - n0 !== 2) begin failures++; $display("FAIL odd_count: got %0d expected 2", vld_cnt - n0); end
        checks++; if (cap_data.size() == 0 || cap_data[0] !== 8'hFF) begin failures++; $display("FAIL odd_bad_data: got %h expected ff", rx_data); end
        checks++; if (cap_perr !== 1'b1) begin failures++; $display("FAIL odd_bad_parity_err: got %b expected 1", cap_perr); end
        parity_en = 1'b0;
    endtask

    task automatic test_break;
        int n0;
        parity_en = 1'b0;
        n0 = vld_cnt;
        cap_data.delete();
        // 0x3C followed by the line held low for three bit times.
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit((8'h3C >> i) & 8'h01 ? 1'b1 : 1'b0);
        rxd = 1'b0;
        wait_ticks(48);
        checks++; if (vld_cnt - n0 !== 1) begin failures++; $display("FAIL break_count: got %0d expected 1", vld_cnt - n0); end
        checks++; if (cap_data.size() == 0 || cap_data[0] !== 8'h3C) begin failures++; $display("FAIL break_data: got %h expected 3c", rx_data); end
        checks++; if (cap_ferr !== 1'b1) begin failures++; $display("FAIL break_frame_err: got %b expected 1", cap_ferr); end
        checks++; if (rx_busy !== 1'b1) begin failures++; $display("FAIL break_busy_held: got %b expected 1", rx_busy); end
        rxd = 1'b1;
        wait_ticks(4);
        checks++; if (rx_busy !== 1'b0) begin failures++; $display("FAIL break_busy_release: got %b expected 0", rx_busy); end
        wait_ticks(16);
        n0 = vld_cnt;
        cap_data.delete();
        send_frame(8'h81, 1'b0, 1'b0, 1'b1);
        wait_ticks(16);
        checks++; if (vld_cnt - n0 !== 1) begin failures++; $display("FAIL after_break_count: got %0d expected 1", vld_cnt - n0); end
        checks++; if (cap_data.size() == 0 || cap_data[0] !== 8'h81) begin failures++; $display("FAIL after_break_data: got %h expected 81", rx_data); end
        checks++; if (cap_ferr !== 1'b0) begin failures++; $display("FAIL after_break_frame_err: got %b expected 0", cap_ferr); end
    endtask

    task automatic test_glitch;
        int n0;
        n0 = vld_cnt;
        cap_data.delete();
        busy_seen = 1'b0;
        rxd = 1'b0;
        wait_ticks(4);
        rxd = 1'b1;
        wait_ticks(32);
        checks++; if (busy_seen !== 1'b0) begin failures++; $display("FAIL glitch_busy: got %b expected 0", busy_seen); end
        checks++; if (vld_cnt - n0 !== 0) begin failures++; $display("FAIL glitch_valid: got %0d expected 0", vld_cnt - n0); end
        send_frame(8'h12, 1'b0, 1'b0, 1'b1);
        wait_ticks(16);
        checks++; if (vld_cnt - n0 !== 1) begin failures++; $display("FAIL glitch_next_count: got %0d expected 1", vld_cnt - n0); end
        checks++; if (cap_data.size() == 0 || cap_data[0] !== 8'h12) begin failures++; $display("FAIL glitch_next_data: got %h expected 12", rx_data); end
    endtask

    task automatic test_reset_midframe;
        int n0;
        n0 = vld_cnt;
        cap_data.delete();
        // 0xF0 frame: start, bits 0..3, then reset halfway through bit 4.
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        rxd = 1'b1;
        wait_ticks(8);
        rst = 1'b0;
        #2;
        checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL midrst_rx_data: got %h expected 00", rx_data); end
        checks++; if (rx_busy !== 1'b0) begin failures++; $display("FAIL midrst_rx_busy: got %b expected 0", rx_busy); end
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL midrst_rx_valid: got %b expected 0", rx_valid); end
        checks++; if (frame_err !== 1'b0 || parity_err !== 1'b0) begin failures++; $display("FAIL midrst_flags: got %b%b expected 00", frame_err, parity_err); end
        repeat (5) @(posedge sysclk);
        #1;
        rst = 1'b1;
        wait_ticks(64);
        checks++; if (vld_cnt - n0 !== 0) begin failures++; $display("FAIL midrst_no_valid: got %0d expected 0", vld_cnt - n0); end
        send_frame(8'h01, 1'b0, 1'b0, 1'b1);
        send_frame(8'hFE, 1'b0, 1'b0, 1'b1);
        wait_ticks(16);
        checks++; if (vld_cnt - n0 !== 2) begin failures++; $display("FAIL b2b_count: got %0d expected 2", vld_cnt - n0); end
        checks++; if (cap_data.size() < 1 || cap_data[0] !== 8'h01) begin failures++; $display("FAIL b2b_first: got %h expected 01", cap_data.size() > 0 ? cap_data[0] : 8'hxx); end
        checks++; if (cap_data.size() < 2 || cap_data[1] !== 8'hFE) begin failures++; $display("FAIL b2b_second: got %h expected fe", rx_data); end
        checks++; if (rx_data !== 8'hFE) begin failures++; $display("FAIL b2b_held: got %h expected fe", rx_data); end
    endtask

    initial begin
        test_reset();
        test_no_parity();
        test_even_parity();
        test_odd_parity();
        test_break();
        test_glitch();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
